// File: rtl/wall_scan_sequencer.sv
// Time-shares the single-port wall ROM across the up/down/left/right ball checks.
// Optional macro WALL_CORNER_CHECK_EN widens the up/down reduction to the corner pixels.
module wall_scan_sequencer #(
  parameter int unsigned BALL_SIZE = 16,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [9:0]          BallX,
  input  logic [9:0]          BallY,
  output logic [9:0]          rom_addr,
  input  logic [SCREEN_W-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                BlockUp,
  output logic                BlockDown,
  output logic                BlockLeft,
  output logic                BlockRight
);
  localparam int unsigned NSLOT = BALL_SIZE + 2;
  localparam int unsigned SW    = $clog2(NSLOT);
  localparam int unsigned DW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int unsigned IW    = $clog2(SCREEN_W);
  localparam logic [SCREEN_W-1:0] WIN_MASK =
    {{(SCREEN_W-BALL_SIZE){1'b0}}, {BALL_SIZE{1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state;
  logic [10:0]                x_q, y_q;
  logic [SW-1:0]              slot;
  logic [DW-1:0]              drain_cnt;
  logic [ROM_LAT-1:0]         tag_vld;
  logic [ROM_LAT-1:0][SW-1:0] tag_slot;
  logic                       acc_up, acc_down, acc_left, acc_right;

  logic                       c_vld;
  logic [SW-1:0]              c_slot;
  logic [10:0]                c_row, x_left, x_right;
  logic [SCREEN_W-1:0]        win;
  logic                       left_bit, right_bit, vert_bit;
  logic                       hit_up, hit_down, hit_left, hit_right;

  // Row for a slot: 0 = above, 1 = below, 2.. = side rows; out-of-range rows read row 0.
  function automatic logic [9:0] slot_addr(input logic [10:0] y, input logic [SW-1:0] s);
    logic [10:0] row;
    if (s == '0)          row = y - 11'd1;
    else if (s == SW'(1)) row = y + 11'(BALL_SIZE);
    else                  row = y + 11'(s) - 11'd2;
    return (row < 11'(SCREEN_H)) ? row[9:0] : '0;
  endfunction

  always_comb begin
    c_vld     = tag_vld[ROM_LAT-1];
    c_slot    = tag_slot[ROM_LAT-1];
    c_row     = y_q + 11'(c_slot) - 11'd2;
    x_left    = x_q - 11'd1;
    x_right   = x_q + 11'(BALL_SIZE);
    win       = (rom_data >> x_q) & WIN_MASK;
    left_bit  = (x_q != '0) && (x_left < 11'(SCREEN_W)) && rom_data[x_left[IW-1:0]];
    right_bit = (x_right < 11'(SCREEN_W)) && rom_data[x_right[IW-1:0]];
    vert_bit  = |win;
`ifdef WALL_CORNER_CHECK_EN
    vert_bit  = vert_bit | left_bit | right_bit;
`endif
    hit_up    = c_vld && (c_slot == '0) && (y_q != '0) && vert_bit;
    hit_down  = c_vld && (c_slot == SW'(1)) &&
                ((y_q + 11'(BALL_SIZE)) < 11'(SCREEN_H)) && vert_bit;
    hit_left  = c_vld && (c_slot >= SW'(2)) && (c_row < 11'(SCREEN_H)) && left_bit;
    hit_right = c_vld && (c_slot >= SW'(2)) && (c_row < 11'(SCREEN_H)) && right_bit;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_addr   <= '0;
      BlockUp    <= 1'b1;
      BlockDown  <= 1'b1;
      BlockLeft  <= 1'b1;
      BlockRight <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      slot       <= '0;
      drain_cnt  <= '0;
      tag_vld    <= '0;
      tag_slot   <= '0;
      acc_up     <= 1'b0;
      acc_down   <= 1'b0;
      acc_left   <= 1'b0;
      acc_right  <= 1'b0;
    end else begin
      tag_vld[0]  <= (state == ISSUE);
      tag_slot[0] <= slot;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_slot[i] <= tag_slot[i-1];
      end
      acc_up    <= acc_up    | hit_up;
      acc_down  <= acc_down  | hit_down;
      acc_left  <= acc_left  | hit_left;
      acc_right <= acc_right | hit_right;

      case (state)
        IDLE: if (start) begin
          x_q       <= {1'b0, BallX};
          y_q       <= {1'b0, BallY};
          slot      <= '0;
          rom_addr  <= slot_addr({1'b0, BallY}, '0);
          // Screen-edge conditions preset the accumulators so their data is never needed.
          acc_up    <= (BallY == '0);
          acc_down  <= (({1'b0, BallY} + 11'(BALL_SIZE)) >= 11'(SCREEN_H));
          acc_left  <= (BallX == '0);
          acc_right <= (({1'b0, BallX} + 11'(BALL_SIZE)) >= 11'(SCREEN_W));
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (slot == SW'(NSLOT-1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            rom_addr  <= '0;
          end else begin
            slot     <= slot + SW'(1);
            rom_addr <= slot_addr(y_q, slot + SW'(1));
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(ROM_LAT-1)) begin
            // Final data word is still in flight this cycle; fold it in directly.
            state      <= DONE;
            done       <= 1'b1;
            BlockUp    <= acc_up    | hit_up;
            BlockDown  <= acc_down  | hit_down;
            BlockLeft  <= acc_left  | hit_left;
            BlockRight <= acc_right | hit_right;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wall_scan_sequencer.sv
// Bench for wall_scan_sequencer: two instances (ROM_LAT=1 and ROM_LAT=3) against a column/row reference model.
module tb_wall_scan_sequencer;
  localparam int BS = 16;
  localparam int W  = 640;
  localparam int H  = 480;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [1:0]   start_s;
  logic [9:0]   BallX, BallY;
  logic [9:0]   ra0, ra1;
  logic [W-1:0] rd0, rd1, p3a, p3b;
  logic [1:0]   busy_s, done_s, up_s, dn_s, lf_s, rt_s;
  logic [W-1:0] rom [H];

  int checks = 0;
  int errors = 0;
  int lat [2] = '{BS + 2 + 1 + 1, BS + 2 + 3 + 1};

  int       ndone [2];
  int       done_at [2][4];
  logic [3:0] fl [2];
  logic     busy_tr [2][64];

  always #5 Clk = ~Clk;

  wall_scan_sequencer #(.ROM_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .start(start_s[0]), .BallX(BallX), .BallY(BallY),
    .rom_addr(ra0), .rom_data(rd0), .busy(busy_s[0]), .done(done_s[0]),
    .BlockUp(up_s[0]), .BlockDown(dn_s[0]), .BlockLeft(lf_s[0]), .BlockRight(rt_s[0]));

  wall_scan_sequencer #(.ROM_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .start(start_s[1]), .BallX(BallX), .BallY(BallY),
    .rom_addr(ra1), .rom_data(rd1), .busy(busy_s[1]), .done(done_s[1]),
    .BlockUp(up_s[1]), .BlockDown(dn_s[1]), .BlockLeft(lf_s[1]), .BlockRight(rt_s[1]));

  // ROM models with 1- and 3-cycle read latency
  always @(posedge Clk) begin
    rd0 <= (ra0 < H) ? rom[ra0] : '0;
    p3a <= (ra1 < H) ? rom[ra1] : '0;
    p3b <= p3a;
    rd1 <= p3b;
  end

  function automatic logic [3:0] ref_flags(input int x, input int y);
    bit u, d, l, r;
    int c0, c1;
    u = (y == 0);
    d = (y + BS >= H);
    l = (x == 0);
    r = (x + BS >= W);
    c0 = x;
    c1 = x + BS - 1;
`ifdef WALL_CORNER_CHECK_EN
    c0 = x - 1;
    c1 = x + BS;
`endif
    for (int c = c0; c <= c1; c++) begin
      if (c >= 0 && c < W) begin
        if (y > 0 && rom[y-1][c]) u = 1;
        if (y + BS < H && rom[y+BS][c]) d = 1;
      end
    end
    for (int row = y; row < y + BS; row++) begin
      if (row < H) begin
        if (x > 0 && x - 1 < W && rom[row][x-1]) l = 1;
        if (x + BS < W && rom[row][x+BS]) r = 1;
      end
    end
    return {u, d, l, r};
  endfunction

  task automatic clear_rom();
    for (int r = 0; r < H; r++) rom[r] = '0;
  endtask

  // Call at a negedge; cycle 0 is the cycle in which start is presented.
  task automatic run_scan(input logic [1:0] m, input int x, input int y,
                          input int pa, input int pb, input int pc, input int ncyc);
    for (int i = 0; i < 2; i++) begin
      ndone[i] = 0;
      fl[i] = 4'h0;
    end
    BallX = 10'(x);
    BallY = 10'(y);
    start_s = m;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) start_s = (c == pa || c == pb || c == pc) ? m : 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (c < 64) busy_tr[i][c] = busy_s[i];
        if (done_s[i]) begin
          if (ndone[i] == 0) fl[i] = {up_s[i], dn_s[i], lf_s[i], rt_s[i]};
          if (ndone[i] < 4) done_at[i][ndone[i]] = c;
          ndone[i]++;
        end
      end
      @(negedge Clk);
    end
    start_s = 2'b00;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start_s = 2'b00;
    BallX = '0;
    BallY = '0;
    clear_rom();
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({up_s[i], dn_s[i], lf_s[i], rt_s[i], busy_s[i], done_s[i]} !== 6'b111100) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b want 111100", i,
                 {up_s[i], dn_s[i], lf_s[i], rt_s[i], busy_s[i], done_s[i]});
      end
    end
    checks++;
    if ({ra0, ra1} !== 20'd0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %0d/%0d want 0/0", ra0, ra1);
    end
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    checks++;
    if ({up_s, dn_s, lf_s, rt_s, busy_s, done_s} !== 12'b111111110000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 111111110000",
               {up_s, dn_s, lf_s, rt_s, busy_s, done_s});
    end
  endtask

  task automatic test_empty();
    int bad;
    clear_rom();
    run_scan(2'b11, 100, 100, -1, -1, -1, 30);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ndone[i] != 1) begin
        errors++;
        $display("FAIL empty_done_count[%0d]: got %0d want 1", i, ndone[i]);
      end
      checks++;
      if (ndone[i] < 1 || done_at[i][0] != lat[i]) begin
        errors++;
        $display("FAIL empty_latency[%0d]: got %0d want %0d", i,
                 (ndone[i] > 0) ? done_at[i][0] : -1, lat[i]);
      end
      checks++;
      if (fl[i] !== 4'b0000) begin
        errors++;
        $display("FAIL empty_flags[%0d]: got %b want 0000", i, fl[i]);
      end
      bad = 0;
      for (int c = 0; c < 30; c++)
        if (busy_tr[i][c] !== ((c >= 1 && c <= lat[i]) ? 1'b1 : 1'b0)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL empty_busy[%0d]: got %0d wrong cycles want 0", i, bad);
      end
    end
  endtask

  task automatic test_up_bit();
    logic [3:0] exp;
    for (int col = 115; col <= 116; col++) begin
      clear_rom();
      rom[99][col] = 1'b1;
      exp = ref_flags(100, 100);
      run_scan(2'b11, 100, 100, -1, -1, -1, 30);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ndone[i] != 1 || fl[i] !== exp) begin
          errors++;
          $display("FAIL up_bit_col%0d[%0d]: got %b (dones %0d) want %b (dones 1)",
                   col, i, fl[i], ndone[i], exp);
        end
      end
    end
  endtask

  task automatic test_sides();
    logic [3:0] exp;
    clear_rom();
    rom[108][99]  = 1'b1;
    rom[110][116] = 1'b1;
    exp = ref_flags(100, 100);
    run_scan(2'b11, 100, 100, -1, -1, -1, 30);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ndone[i] != 1 || fl[i] !== exp) begin
        errors++;
        $display("FAIL sides[%0d]: got %b want %b", i, fl[i], exp);
      end
    end
  endtask

  task automatic test_boundaries();
    int xs [2] = '{0, 624};
    int ys [2] = '{0, 464};
    logic [3:0] exp;
    clear_rom();
    for (int k = 0; k < 2; k++) begin
      exp = ref_flags(xs[k], ys[k]);
      run_scan(2'b11, xs[k], ys[k], -1, -1, -1, 30);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ndone[i] != 1 || done_at[i][0] != lat[i] || fl[i] !== exp) begin
          errors++;
          $display("FAIL boundary_%0d_%0d[%0d]: got %b at %0d want %b at %0d",
                   xs[k], ys[k], i, fl[i], (ndone[i] > 0) ? done_at[i][0] : -1, exp, lat[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int x, y, rr, cc, sel;
    logic [3:0] exp;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      x = (sel == 0) ? 0 : (sel == 1) ? 624 + $urandom_range(0, 15) : $urandom_range(0, W - 1);
      sel = $urandom_range(0, 9);
      y = (sel == 0) ? 0 : (sel == 1) ? 464 + $urandom_range(0, 15) : $urandom_range(0, H - 1);
      clear_rom();
      for (int k = 0; k < $urandom_range(0, 4); k++) begin
        rr = y - 1 + $urandom_range(0, 17);
        cc = x - 1 + $urandom_range(0, 17);
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) rom[rr][cc] = 1'b1;
      end
      for (int k = 0; k < 3; k++) rom[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 1'b1;
      exp = ref_flags(x, y);
      run_scan(2'b11, x, y, -1, -1, -1, 26);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ndone[i] != 1 || done_at[i][0] != lat[i] || fl[i] !== exp) begin
          errors++;
          $display("FAIL random_x%0d_y%0d[%0d]: got %b at %0d want %b at %0d", x, y, i,
                   fl[i], (ndone[i] > 0) ? done_at[i][0] : -1, exp, lat[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    clear_rom();
    rom[120][300] = 1'b1;
    exp = ref_flags(300, 104);
    for (int i = 0; i < 2; i++) begin
      run_scan(2'(1 << i), 300, 104, 5, lat[i], lat[i] + 1, 2 * lat[i] + 5);
      checks++;
      if (ndone[i] != 2) begin
        errors++;
        $display("FAIL b2b_done_count[%0d]: got %0d want 2", i, ndone[i]);
      end
      checks++;
      if (ndone[i] < 2 || done_at[i][0] != lat[i] || done_at[i][1] != 2 * lat[i] + 1) begin
        errors++;
        $display("FAIL b2b_done_cycles[%0d]: got %0d,%0d want %0d,%0d", i,
                 (ndone[i] > 0) ? done_at[i][0] : -1, (ndone[i] > 1) ? done_at[i][1] : -1,
                 lat[i], 2 * lat[i] + 1);
      end
      checks++;
      if (fl[i] !== exp) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got %b want %b", i, fl[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    logic [3:0] exp;
    clear_rom();
    rom[49][210] = 1'b1;
    BallX = 10'd200;
    BallY = 10'd50;
    start_s = 2'b11;
    @(negedge Clk);
    start_s = 2'b00;
    repeat (9) @(negedge Clk);
    checks++;
    if (busy_s !== 2'b11) begin
      errors++;
      $display("FAIL busy_before_reset: got %b want 11", busy_s);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({busy_s, done_s, up_s, dn_s, lf_s, rt_s} !== 12'b000011111111) begin
      errors++;
      $display("FAIL async_reset: got %b want 000011111111",
               {busy_s, done_s, up_s, dn_s, lf_s, rt_s});
    end
    @(negedge Clk);
    Reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (done_s !== 2'b00) nd++;
      @(negedge Clk);
    end
    checks++;
    if (nd != 0 || {up_s, dn_s, lf_s, rt_s} !== 8'hFF) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d dones flags %b want 0 dones flags 11111111",
               nd, {up_s, dn_s, lf_s, rt_s});
    end
    exp = ref_flags(200, 50);
    run_scan(2'b11, 200, 50, -1, -1, -1, 30);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ndone[i] != 1 || done_at[i][0] != lat[i] || fl[i] !== exp) begin
        errors++;
        $display("FAIL rescan_after_reset[%0d]: got %b at %0d want %b at %0d", i, fl[i],
                 (ndone[i] > 0) ? done_at[i][0] : -1, exp, lat[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_up_bit();
    test_sides();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
